// File: rtl/keypad_defs_pkg.sv
// Shared keypad/renderer definitions: FSM encodings, one-cold column strobes,
// frame classification and the blank-digit graphics value.
package keypad_defs_pkg;

  localparam logic [1:0] ST_IDLE     = 2'd0;
  localparam logic [1:0] ST_DEBOUNCE = 2'd1;
  localparam logic [1:0] ST_PRESSED  = 2'd2;
  localparam logic [1:0] ST_RELEASE  = 2'd3;

  // Same one-cold order the 7-segment renderer uses for digit select.
  localparam logic [3:0] COL_0 = 4'b1110;
  localparam logic [3:0] COL_1 = 4'b1101;
  localparam logic [3:0] COL_2 = 4'b1011;
  localparam logic [3:0] COL_3 = 4'b0111;

  localparam logic [3:0]  BLANK_NIBBLE   = 4'hF;
  localparam logic [15:0] GRAPHICS_RESET = {4{BLANK_NIBBLE}};

  typedef enum logic [1:0] {
    FRAME_NONE   = 2'd0,
    FRAME_SINGLE = 2'd1,
    FRAME_MULTI  = 2'd2
  } frame_class_t;

  function automatic logic [3:0] col_onecold(input logic [1:0] idx);
    case (idx)
      2'd0:    col_onecold = COL_0;
      2'd1:    col_onecold = COL_1;
      2'd2:    col_onecold = COL_2;
      default: col_onecold = COL_3;
    endcase
  endfunction

endpackage

// File: rtl/keypad_debouncer.sv
// Frame-level press/release debouncer: accepts a key after DEBOUNCE_FRAMES
// matching single-hit frames and releases after as many empty frames.
module keypad_debouncer
  import keypad_defs_pkg::*;
#(
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         frame_end,
  input  frame_class_t frame_class,
  input  logic [3:0]   frame_code,
  output logic         accept,
  output logic [3:0]   code,
  output logic         held
);

  localparam int CNT_W = (DEBOUNCE_FRAMES > 2) ? $clog2(DEBOUNCE_FRAMES) : 1;
  // cnt+1 == DEBOUNCE_FRAMES expressed on the stored count
  localparam logic [CNT_W-1:0] CNT_DONE = CNT_W'(DEBOUNCE_FRAMES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

  logic [1:0]       state_reg;
  logic [CNT_W-1:0] cnt_reg;
  logic [3:0]       cand_reg;
  logic             accept_reg;
  logic [3:0]       code_reg;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_reg  <= ST_IDLE;
      cnt_reg    <= '0;
      cand_reg   <= 4'h0;
      accept_reg <= 1'b0;
      code_reg   <= 4'h0;
    end else begin
      accept_reg <= 1'b0;
      if (frame_end) begin
        case (state_reg)
          ST_IDLE: begin
            if (frame_class == FRAME_SINGLE) begin
              cand_reg  <= frame_code;
              cnt_reg   <= CNT_ONE;
              state_reg <= ST_DEBOUNCE;
            end
          end
          ST_DEBOUNCE: begin
            if (frame_class == FRAME_SINGLE && frame_code == cand_reg) begin
              if (cnt_reg == CNT_DONE) begin
                state_reg  <= ST_PRESSED;
                accept_reg <= 1'b1;
                code_reg   <= cand_reg;
              end else begin
                cnt_reg <= cnt_reg + CNT_ONE;
              end
            end else begin
              state_reg <= ST_IDLE;
            end
          end
          ST_PRESSED: begin
            if (frame_class == FRAME_NONE) begin
              cnt_reg   <= CNT_ONE;
              state_reg <= ST_RELEASE;
            end
          end
          default: begin
            if (frame_class != FRAME_NONE) begin
              state_reg <= ST_PRESSED;
            end else if (cnt_reg == CNT_DONE) begin
              state_reg <= ST_IDLE;
            end else begin
              cnt_reg <= cnt_reg + CNT_ONE;
            end
          end
        endcase
      end
    end
  end

  assign accept = accept_reg;
  assign code   = code_reg;
  assign held   = (state_reg == ST_PRESSED) || (state_reg == ST_RELEASE);

endmodule

// File: rtl/keypad_scanner.sv
// 4x4 matrix keypad scanner: rotates a one-cold column strobe, samples rows at
// the end of each dwell, classifies whole frames and feeds the debouncer.
module keypad_scanner
  import keypad_defs_pkg::*;
#(
  parameter int SCAN_DIV        = 100000,
  parameter int DEBOUNCE_FRAMES = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [3:0]  row,
  output logic [3:0]  col_sel,
  output logic [3:0]  key_code,
  output logic        key_valid,
  output logic        key_held,
  output logic [15:0] graphics
);

  localparam int CW = (SCAN_DIV > 2) ? $clog2(SCAN_DIV) : 1;
  localparam logic [CW-1:0] DWELL_LAST = CW'(SCAN_DIV - 1);

  logic [CW-1:0] dwell_reg;
  logic [1:0]    col_idx_reg;
  logic [3:0]    row_meta_reg;
  logic [3:0]    row_sync_reg;
  logic [1:0]    hit_cnt_reg;
  logic [3:0]    first_code_reg;
  logic [15:0]   history_reg;

  logic         sample;
  logic         frame_end;
  logic [1:0]   col_hits;
  logic [1:0]   col_first_row;
  logic [2:0]   hit_sum;
  logic [1:0]   hit_total;
  logic [3:0]   frame_code;
  frame_class_t frame_class;

  assign sample    = (dwell_reg == DWELL_LAST);
  assign frame_end = sample && (col_idx_reg == 2'd3);
  assign col_sel   = col_onecold(col_idx_reg);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dwell_reg    <= '0;
      col_idx_reg  <= 2'd0;
      row_meta_reg <= 4'hF;
      row_sync_reg <= 4'hF;
    end else begin
      row_meta_reg <= row;
      row_sync_reg <= row_meta_reg;
      if (sample) begin
        dwell_reg   <= '0;
        col_idx_reg <= col_idx_reg + 2'd1;
      end else begin
        dwell_reg <= dwell_reg + CW'(1);
      end
    end
  end

  // Hits in the current column; the lowest-numbered row wins as first code.
  always_comb begin
    col_hits      = 2'd0;
    col_first_row = 2'd0;
    for (int r = 3; r >= 0; r--) begin
      if (!row_sync_reg[r]) begin
        col_first_row = 2'(r);
        if (col_hits != 2'd2) col_hits = col_hits + 2'd1;
      end
    end
    hit_sum    = {1'b0, hit_cnt_reg} + {1'b0, col_hits};
    hit_total  = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    frame_code = (hit_cnt_reg == 2'd0) ? {col_first_row, col_idx_reg} : first_code_reg;
    case (hit_total)
      2'd0:    frame_class = FRAME_NONE;
      2'd1:    frame_class = FRAME_SINGLE;
      default: frame_class = FRAME_MULTI;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      hit_cnt_reg    <= 2'd0;
      first_code_reg <= 4'h0;
    end else if (sample) begin
      if (frame_end) begin
        hit_cnt_reg    <= 2'd0;
        first_code_reg <= 4'h0;
      end else begin
        hit_cnt_reg    <= hit_total;
        first_code_reg <= frame_code;
      end
    end
  end

  keypad_debouncer #(
    .DEBOUNCE_FRAMES(DEBOUNCE_FRAMES)
  ) u_debouncer (
    .clk        (clk),
    .rst_n      (rst_n),
    .frame_end  (frame_end),
    .frame_class(frame_class),
    .frame_code (frame_code),
    .accept     (key_valid),
    .code       (key_code),
    .held       (key_held)
  );

  // The new nibble shows during the key_valid cycle and is committed at its end.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      history_reg <= GRAPHICS_RESET;
    end else if (key_valid) begin
      history_reg <= {history_reg[11:0], key_code};
    end
  end

  assign graphics = key_valid ? {history_reg[11:0], key_code} : history_reg;

endmodule

// File: tb/tb_keypad_scanner.sv
// Self-checking bench for keypad_scanner: a simulated 4x4 key matrix driven by
// col_sel, directed scenarios plus random key patterns against a frame model.
module tb_keypad_scanner;

  localparam int SD = 8;
  localparam int DF = 3;
  localparam int FRAME = 4 * SD;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [3:0]  row;
  logic [3:0]  col_sel;
  logic [3:0]  key_code;
  logic        key_valid;
  logic        key_held;
  logic [15:0] graphics;

  logic [15:0] keys = 16'h0000;   // bit r*4+c set = key (row r, column c) pressed

  int checks = 0;
  int failures = 0;
  int pulses = 0;
  bit run_cmp = 1'b0;

  keypad_scanner #(.SCAN_DIV(SD), .DEBOUNCE_FRAMES(DF)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .row      (row),
    .col_sel  (col_sel),
    .key_code (key_code),
    .key_valid(key_valid),
    .key_held (key_held),
    .graphics (graphics)
  );

  always #5 clk = ~clk;

  // Passive key matrix: a pressed key shorts its row to its column strobe.
  always_comb begin
    row = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (keys[r*4+c] && !col_sel[c]) row[r] = 1'b0;
  end

  // Behavioural model. m_e = clock edges since reset release.
  int          m_e = 0;
  logic [3:0]  m_h1 = 4'hF, m_h2 = 4'hF;   // row seen 1 and 2 edges ago
  int          m_hits = 0;
  logic [3:0]  m_first = 4'h0;
  int          m_streak = 0;
  logic [3:0]  m_cand = 4'h0;
  bit          m_held = 1'b0;
  int          m_quiet = 0;
  bit          exp_valid = 1'b0;
  logic [3:0]  exp_code = 4'h0;
  logic [15:0] exp_graph = 16'hFFFF;
  int          m_col;
  int          m_cls;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_e = 0; m_h1 = 4'hF; m_h2 = 4'hF; m_hits = 0; m_first = 4'h0;
      m_streak = 0; m_cand = 4'h0; m_held = 1'b0; m_quiet = 0;
      exp_valid = 1'b0; exp_code = 4'h0; exp_graph = 16'hFFFF;
    end else begin
      m_e++;
      exp_valid = 1'b0;
      if (m_e % SD == 0) begin
        m_col = ((m_e - 1) / SD) % 4;
        for (int r = 0; r < 4; r++)
          if (!m_h2[r]) begin
            if (m_hits == 0) m_first = 4'(r * 4 + m_col);
            m_hits++;
          end
        if (m_col == 3) begin
          m_cls = (m_hits == 0) ? 0 : (m_hits == 1) ? 1 : 2;
          if (!m_held) begin
            if (m_cls == 1 && m_streak > 0 && m_first == m_cand) m_streak++;
            else if (m_cls == 1 && m_streak == 0) begin m_cand = m_first; m_streak = 1; end
            else m_streak = 0;
            if (m_streak == DF) begin
              exp_valid = 1'b1;
              exp_code  = m_cand;
              exp_graph = {exp_graph[11:0], m_cand};
              m_held = 1'b1; m_quiet = 0; m_streak = 0;
            end
          end else begin
            if (m_cls == 0) m_quiet++; else m_quiet = 0;
            if (m_quiet == DF) begin m_held = 1'b0; m_quiet = 0; end
          end
          m_hits = 0;
        end
      end
      m_h2 = m_h1;
      m_h1 = row;
    end
  end

  task automatic check(input string name, input logic [15:0] act, input logic [15:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  logic [3:0] exp_col;
  always @(negedge clk) begin
    if (run_cmp) begin
      exp_col = ~(4'b0001 << ((m_e / SD) % 4));
      check("col_sel", {12'h0, col_sel}, {12'h0, exp_col});
      check("key_valid", {15'h0, key_valid}, {15'h0, exp_valid});
      check("key_code", {12'h0, key_code}, {12'h0, exp_code});
      check("key_held", {15'h0, key_held}, {15'h0, m_held});
      check("graphics", graphics, exp_graph);
    end
    if (key_valid) begin
      pulses++;
      $display("key accepted edge=%0d code=%h graphics=%h", m_e, key_code, graphics);
    end
  end

  task automatic edges(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_pulse(input int limit, output int at_e);
    at_e = -1;
    for (int i = 0; i < limit; i++) begin
      @(posedge clk); #1;
      if (key_valid) begin at_e = m_e; break; end
    end
  endtask

  task automatic align_frame();
    for (int i = 0; i < FRAME && (m_e % FRAME != 0); i++) edges(1);
  endtask

  int p0;
  int at;
  int sel;

  initial begin
    // 1: idle scan after reset
    edges(3);
    rst_n = 1'b1;
    run_cmp = 1'b1;
    check("t1_col_e0", {12'h0, col_sel}, 16'h000E);
    edges(7);
    check("t1_col_e7", {12'h0, col_sel}, 16'h000E);
    edges(1);
    check("t1_col_e8", {12'h0, col_sel}, 16'h000D);
    p0 = pulses;
    edges(10 * FRAME);
    check("t1_no_valid", 16'(pulses - p0), 16'd0);
    check("t1_graphics", graphics, 16'hFFFF);

    // 3: key r1,c2 for only two frames
    align_frame();
    p0 = pulses;
    keys = 16'h0040;
    edges(2 * FRAME);
    keys = 16'h0000;
    edges(5 * FRAME);
    check("t3_no_valid", 16'(pulses - p0), 16'd0);
    check("t3_graphics", graphics, 16'hFFFF);
    check("t3_held", {15'h0, key_held}, 16'd0);

    // 4: two keys in column 0
    align_frame();
    p0 = pulses;
    keys = 16'h0011;
    edges(5 * FRAME);
    check("t4_no_valid", 16'(pulses - p0), 16'd0);
    check("t4_held", {15'h0, key_held}, 16'd0);
    keys = 16'h0000;
    edges(3 * FRAME);

    // 2: key r1,c2 held from frame 0 after a fresh reset
    rst_n = 1'b0;
    keys = 16'h0040;
    edges(2);
    rst_n = 1'b1;
    wait_pulse(200, at);
    check("t2_latency", 16'(at), 16'd96);
    check("t2_code", {12'h0, key_code}, 16'h0006);
    check("t2_graphics", graphics, 16'hFFF6);
    check("t2_held", {15'h0, key_held}, 16'd1);
    edges(1);
    check("t2_pulse_width", {15'h0, key_valid}, 16'd0);

    // 5: release, then key r1,c1
    keys = 16'h0000;
    edges(4 * FRAME);
    check("t5_released", {15'h0, key_held}, 16'd0);
    p0 = pulses;
    keys = 16'h0020;
    edges(10 * FRAME);
    check("t5_one_pulse", 16'(pulses - p0), 16'd1);
    check("t5_code", {12'h0, key_code}, 16'h0005);
    check("t5_graphics", graphics, 16'hFF65);
    check("t5_held", {15'h0, key_held}, 16'd1);

    // 6: asynchronous reset while held, key stays down
    @(posedge clk);
    #3 rst_n = 1'b0;
    #1;
    check("t6_col", {12'h0, col_sel}, 16'h000E);
    check("t6_code", {12'h0, key_code}, 16'h0000);
    check("t6_valid", {15'h0, key_valid}, 16'd0);
    check("t6_held", {15'h0, key_held}, 16'd0);
    check("t6_graphics", graphics, 16'hFFFF);
    edges(2);
    rst_n = 1'b1;
    wait_pulse(200, at);
    check("t6_latency", 16'(at), 16'd96);
    check("t6_graphics_after", graphics, 16'hFFF5);

    // random key activity, checked every cycle by the model
    for (int s = 0; s < 50; s++) begin
      sel = $urandom_range(0, 9);
      if (sel < 4)      keys = 16'h0000;
      else if (sel < 8) keys = 16'h0001 << $urandom_range(0, 15);
      else              keys = (16'h0001 << $urandom_range(0, 15)) | (16'h0001 << $urandom_range(0, 15));
      edges($urandom_range(10, 200));
    end
    keys = 16'h0000;
    edges(5 * FRAME);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/keypad_scanner.md
Name: keypad_scanner

Overview:
- Reads a 4x4 matrix keypad using the same scan-multiplexing scheme the 7-segment renderer uses for output.
- Rotates an active-low column strobe and samples the four row lines.
- Debounces presses and releases over whole scan frames.
- For each debounced press: emits a 4-bit key code and shifts it into a 16-bit nibble register, which connects directly to the renderer's graphics input.

Parameters:
- SCAN_DIV, 100000: clock cycles each column stays selected (dwell). Must be >= 4.
- DEBOUNCE_FRAMES, 4: consecutive identical frames needed to accept a press or a release. Must be >= 2.

Ports:
- clk  input  1  system clock
- rst_n  input  1  asynchronous active-low reset
- row  input  4  keypad rows, active-low, pulled up, asynchronous to clk
- col_sel  output  4  column strobe, active-low, one-cold
- key_code  output  4  code of the last accepted key
- key_valid  output  1  one-cycle pulse when a press is accepted
- key_held  output  1  high while an accepted key is still considered pressed
- graphics  output  16  nibble history, newest key in [3:0]

Behaviour:
- Reset (async, rst_n=0) forces immediately:
  - col_sel=4'b1110, dwell counter 0, column index 0.
  - Row synchronizer flops 4'hF, FSM state IDLE, frame accumulators cleared.
  - key_code=0, key_valid=0, key_held=0, graphics=16'hFFFF (all digits off).
- Scan timing:
  - Dwell counter counts 0..SCAN_DIV-1, then wraps.
  - On wrap, col_sel rotates 1110->1101->1011->0111->1110. Column index is 0..3 respectively.
- Row sampling:
  - row passes through a 2-flop synchronizer.
  - The synchronized value is sampled only on the cycle where counter==SCAN_DIV-1, i.e. the last cycle of the dwell, before col_sel changes.
- Hit accumulation within one frame (4 dwells):
  - Each low bit in the sample is one hit at (row index r, current column c).
  - Key code = {r[1:0], c[1:0]}.
  - The accumulator tracks hit count (saturating at 2) and the code of the first hit.
- Frame end is the sample cycle of column 3. The frame classifies as NONE (0 hits), SINGLE(code) (1 hit) or MULTI (>=2 hits). Accumulators then clear for the next frame.
- FSM transitions are evaluated at frame end only:
  - IDLE:
    - SINGLE -> cand<=code, cnt<=1, DEBOUNCE.
    - NONE/MULTI -> stay.
  - DEBOUNCE:
    - SINGLE with code==cand -> cnt+1.
    - When cnt+1==DEBOUNCE_FRAMES -> PRESSED. On the next clk: key_valid=1 for one cycle, key_code<=cand, graphics<={graphics[11:0],cand}.
    - NONE, MULTI or a different code -> IDLE (no output).
  - PRESSED (key_held=1):
    - NONE -> cnt<=1, RELEASE.
    - SINGLE/MULTI -> stay. No repeat pulses.
  - RELEASE (key_held=1):
    - NONE -> cnt+1; when cnt+1==DEBOUNCE_FRAMES -> IDLE, key_held=0.
    - Any hit -> PRESSED.
- Latency: key_valid rises 1 cycle after the frame end of the DEBOUNCE_FRAMES-th consecutive matching frame.
- key_code and graphics change only in the same cycle key_valid is high.
- graphics shift: 4 accepted keys fill all digits; the oldest nibble drops off [15:12]. Code 4'hF is a legal key and renders as blank.
- A press beginning mid-frame:
  - The partial frame counts only if the row is sampled low during its column's sample cycle.
  - Otherwise the first full frame starts debounce.
- Reset mid-operation: all state clears asynchronously. A key still held after reset must debounce again from IDLE.

Decomposition:
- Shared package/include keypad_defs holds:
  - FSM state encodings (IDLE, DEBOUNCE, PRESSED, RELEASE).
  - One-cold column constants 4'b1110/1101/1011/0111, shared with the renderer's digit-select sequence.
  - Blank nibble 4'hF and graphics reset value 16'hFFFF.
- One sub-module, keypad_debouncer, contains the frame-level FSM and counter. Inputs: frame_end, frame_class, frame_code. Outputs: accept pulse, code, held.
- The scan counter, synchronizer and accumulator stay in keypad_scanner.

Test Plan (SCAN_DIV=8, DEBOUNCE_FRAMES=3, frame=32 cycles):
1. Release rst_n, rows 4'hF -> col_sel=1110 for cycles 0-7, then 1101; graphics=16'hFFFF; key_valid never asserted over 10 frames.
2. Drive row=4'b1101 whenever col_sel=1011 (key r1,c2), sustained from frame 0 -> one key_valid pulse 1 cycle after the frame 2 end; key_code=4'h6; graphics=16'hFFF6; key_held=1.
3. Same key for only 2 frames, then released -> no key_valid; graphics unchanged; FSM back in IDLE.
4. Two keys at once (row=4'b1100 during column 0) for 5 frames -> no key_valid; key_held=0.
5. After test 2, release for 3 frames (key_held falls), then hold key r1,c1 for 10 frames -> exactly one pulse; key_code=4'h5; graphics=16'hFF65.
6. Assert rst_n=0 asynchronously while key_held=1 -> all outputs return to reset values immediately. Key kept held after release of reset -> a new pulse arrives only after 3 full frames.
